systolic_tile_ctrl: RTL and testbench
=====================================

Name: systolic_tile_ctrl

Overview:
- Sequencer for a ROWS x COLS systolic array of multiply-accumulate PEs. Each PE forwards its operands and accumulates c += a*b with one-cycle latency.
- Per tile, the block:
  - clears the accumulators;
  - streams K operand vectors out of the A and B operand buffers, with a one-cycle skew per row and per column;
  - waits for the wavefront to leave the array;
  - drains results one row per valid/ready handshake.
- Sits between the host command interface and the PE array and its operand buffers.

Parameters:
- ROWS, 4, array rows (PE rows fed by A).
- COLS, 4, array columns (PE columns fed by B).
- K_MAX, 256, maximum inner dimension. Operand buffer depth.
- ADDR_W, $clog2(K_MAX), operand buffer address width.
- ROW_W, $clog2(ROWS) (minimum 1), result row index width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, tile start request. Sampled only in IDLE.
- k_len, input, ADDR_W+1, inner dimension, 0..K_MAX. Latched on an accepted start.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at tile completion.
- a_rd_en, output, 1, A buffer read enable.
- a_rd_addr, output, ADDR_W, A buffer read address.
- b_rd_en, output, 1, B buffer read enable.
- b_rd_addr, output, ADDR_W, B buffer read address.
- row_feed_en, output, ROWS, per-row operand-valid into the array's west edge.
- col_feed_en, output, COLS, per-column operand-valid into the array's north edge.
- acc_clr, output, 1, synchronous clear of all PE accumulators.
- res_valid, output, 1, result row available.
- res_row, output, ROW_W, index of the row being drained.
- res_ready, input, 1, downstream accepts the result row.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0: busy, done, a_rd_en, b_rd_en, both addresses, row_feed_en, col_feed_en, acc_clr, res_valid, res_row.
  - Skew shift registers and counters cleared.
  - Reset mid-operation abandons the tile; no done is issued.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE. All outputs are registered and state-decoded.
- IDLE:
  - start=1 with k_len>0: latch k_len, go to CLEAR.
  - start=1 with k_len=0: go straight to DONE. No reads, no clear, no drain.
  - start while busy is ignored.
- CLEAR: acc_clr=1 for exactly 1 cycle.
- FEED:
  - Lasts exactly k_len cycles.
  - a_rd_en=b_rd_en=1 on every FEED cycle.
  - Both addresses go 0,1,…,k_len-1 in the same cycle.
  - k_len=K_MAX reaches address K_MAX-1. The address counter must not wrap before exit.
- Feed skew:
  - The buffers have 1-cycle read latency.
  - row_feed_en[r] = a_rd_en delayed by 1+r cycles.
  - col_feed_en[c] = b_rd_en delayed by 1+c cycles.
  - The delay chains run in all states, so the enables trail into FLUSH.
- FLUSH:
  - Lasts exactly ROWS+COLS cycles.
  - Covers buffer latency, ROWS-1 + COLS-1 skew, and 1 PE cycle.
  - No reads in FLUSH.
- DRAIN:
  - res_valid=1 and res_row=current row, starting at 0.
  - On res_valid & res_ready, res_row increments.
  - The handshake on row ROWS-1 exits to DONE.
  - res_row holds stable while res_ready=0.
- DONE: done=1 for 1 cycle; busy=1 in this cycle. Next state IDLE.
- Latency with res_ready held at 1: start accepted at edge 0 -> done high 2+k_len+ROWS+COLS+ROWS cycles later.

Test Plan:
- ROWS=COLS=4, k_len=4, res_ready=1, start accepted at cycle 0 -> required response:
  - acc_clr at cycle 1.
  - Reads at cycles 2..5, addresses 0..3.
  - row_feed_en[3] high at cycles 6..9.
  - FLUSH at cycles 6..13.
  - res_valid at cycles 14..17 with res_row 0..3.
  - done at cycle 18.
- k_len=0 start -> DONE the next cycle, done pulse. No rd_en, acc_clr or res_valid at any point.
- k_len=K_MAX=256 -> 256 reads, addresses 0..255 with no repeat. 8 FLUSH cycles follow.
- Drain backpressure: res_ready=0 for 5 cycles on row 1 -> res_row holds at 1 with res_valid=1. Exactly 4 handshakes total. done fires 1 cycle after the 4th.
- start pulses during FEED and DRAIN -> ignored, one done only. A start asserted in the IDLE cycle after done begins a new tile with acc_clr.
- rst_n asserted at the 3rd FEED cycle -> all outputs 0 asynchronously. No done. State is IDLE after release. A subsequent start with k_len=2 completes normally.

Source files
------------

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for a ROWS x COLS systolic MAC array: clear, skewed operand feed,
// wavefront flush and row-by-row result drain over a valid/ready handshake.
module systolic_tile_ctrl #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int K_MAX  = 256,
   parameter int ADDR_W = $clog2(K_MAX),
   parameter int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   k_len,
   output logic              busy,
   output logic              done,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_rd_addr,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] b_rd_addr,
   output logic [ROWS-1:0]   row_feed_en,
   output logic [COLS-1:0]   col_feed_en,
   output logic              acc_clr,
   output logic              res_valid,
   output logic [ROW_W-1:0]  res_row,
   input  logic              res_ready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_FLUSH = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Flush covers buffer latency, both skews and the final PE cycle.
   localparam logic [ADDR_W:0]  FLUSH_LEN = (ADDR_W+1)'(ROWS + COLS);
   localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);

   state_t              state_q;
   logic [ADDR_W:0]     k_q;
   logic [ADDR_W:0]     cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                rd_en_q;
   logic                busy_q;
   logic                done_q;
   logic                acc_clr_q;
   logic                res_valid_q;
   logic [ROW_W-1:0]    row_q;
   logic [ROWS-1:0]     row_fe_q;
   logic [COLS-1:0]     col_fe_q;

   // Tile sequencing FSM; every output register is written alongside the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         acc_clr_q   <= 1'b0;
         res_valid_q <= 1'b0;
         row_q       <= '0;
      end else begin
         acc_clr_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (k_len != '0) begin
                     k_q       <= k_len;
                     state_q   <= S_CLEAR;
                     acc_clr_q <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               state_q <= S_FEED;
               rd_en_q <= 1'b1;
               addr_q  <= '0;
               cnt_q   <= CNT_ONE;
            end
            S_FEED: begin
               // cnt_q is one wider than the address, so k_len = K_MAX exits cleanly.
               if (cnt_q == k_q) begin
                  state_q <= S_FLUSH;
                  rd_en_q <= 1'b0;
                  addr_q  <= '0;
                  cnt_q   <= CNT_ONE;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
                  cnt_q  <= cnt_q + CNT_ONE;
               end
            end
            S_FLUSH: begin
               if (cnt_q == FLUSH_LEN) begin
                  state_q     <= S_DRAIN;
                  res_valid_q <= 1'b1;
                  row_q       <= '0;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_DRAIN: begin
               if (res_ready) begin
                  if (row_q == LAST_ROW) begin
                     state_q     <= S_DONE;
                     res_valid_q <= 1'b0;
                     row_q       <= '0;
                     done_q      <= 1'b1;
                  end else begin
                     row_q <= row_q + ROW_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               rd_en_q     <= 1'b0;
               busy_q      <= 1'b0;
               res_valid_q <= 1'b0;
               addr_q      <= '0;
               cnt_q       <= '0;
               row_q       <= '0;
            end
         endcase
      end
   end

   // Skew chains: lane n sees the read enable 1+n cycles later, free-running in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_fe_q <= '0;
         col_fe_q <= '0;
      end else begin
         row_fe_q[0] <= rd_en_q;
         for (int r = 1; r < ROWS; r++) begin
            row_fe_q[r] <= row_fe_q[r-1];
         end
         col_fe_q[0] <= rd_en_q;
         for (int c = 1; c < COLS; c++) begin
            col_fe_q[c] <= col_fe_q[c-1];
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign a_rd_en     = rd_en_q;
   assign b_rd_en     = rd_en_q;
   assign a_rd_addr   = addr_q;
   assign b_rd_addr   = addr_q;
   assign row_feed_en = row_fe_q;
   assign col_feed_en = col_fe_q;
   assign acc_clr     = acc_clr_q;
   assign res_valid   = res_valid_q;
   assign res_row     = row_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboard bench for systolic_tile_ctrl: directed tiles push timed expectations,
// a negedge monitor pops and compares each observed output event.
module tb_systolic_tile_ctrl;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int K_MAX  = 256;
   localparam int ADDR_W = 8;
   localparam int ROW_W  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W:0]   k_len;
   logic              busy, done, a_rd_en, b_rd_en, acc_clr, res_valid, res_ready;
   logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
   logic [ROWS-1:0]   row_feed_en;
   logic [COLS-1:0]   col_feed_en;
   logic [ROW_W-1:0]  res_row;
   logic [31:0]       all_outs;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {int cyc; int data;} exp_t;
   exp_t q_clr[$], q_rd[$], q_rf[$], q_cf[$], q_hs[$], q_st[$], q_done[$];

   systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
      .busy(busy), .done(done),
      .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
      .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
      .row_feed_en(row_feed_en), .col_feed_en(col_feed_en),
      .acc_clr(acc_clr), .res_valid(res_valid), .res_row(res_row),
      .res_ready(res_ready)
   );

   assign all_outs = {busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
                      row_feed_en, col_feed_en, acc_clr, res_valid, res_row};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int rd_word(input int addr);
      return (1 << 17) | (1 << 16) | (addr << 8) | addr;
   endfunction

   function automatic void push(input int kind, input int c, input int d);
      exp_t e;
      e.cyc  = c;
      e.data = d;
      case (kind)
         0: q_clr.push_back(e);
         1: q_rd.push_back(e);
         2: q_rf.push_back(e);
         3: q_cf.push_back(e);
         4: q_hs.push_back(e);
         5: q_st.push_back(e);
         default: q_done.push_back(e);
      endcase
   endfunction

   task automatic got(input int kind, input int data);
      exp_t  e;
      bit    have;
      string nm;
      have = 1'b0;
      e.cyc = 0;
      e.data = 0;
      case (kind)
         0: begin nm = "acc_clr";   if (q_clr.size() > 0)  begin e = q_clr.pop_front();  have = 1'b1; end end
         1: begin nm = "rd";        if (q_rd.size() > 0)   begin e = q_rd.pop_front();   have = 1'b1; end end
         2: begin nm = "row_feed3"; if (q_rf.size() > 0)   begin e = q_rf.pop_front();   have = 1'b1; end end
         3: begin nm = "col_feed3"; if (q_cf.size() > 0)   begin e = q_cf.pop_front();   have = 1'b1; end end
         4: begin nm = "res_hs";    if (q_hs.size() > 0)   begin e = q_hs.pop_front();   have = 1'b1; end end
         5: begin nm = "res_stall"; if (q_st.size() > 0)   begin e = q_st.pop_front();   have = 1'b1; end end
         default: begin nm = "done"; if (q_done.size() > 0) begin e = q_done.pop_front(); have = 1'b1; end end
      endcase
      total++;
      if (!have) begin
         bad++;
         $display("FAIL %s: unexpected event at cycle %0d data %0h", nm, cyc, data);
      end else if (e.cyc != cyc || e.data != data) begin
         bad++;
         $display("FAIL %s: got cycle %0d data %0h, want cycle %0d data %0h", nm, cyc, data, e.cyc, e.data);
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: every visible output event is matched against the scoreboard.
   always @(negedge clk) begin
      if (acc_clr) got(0, 0);
      if (a_rd_en || b_rd_en) got(1, int'({14'd0, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr}));
      if (row_feed_en[ROWS-1]) got(2, 0);
      if (col_feed_en[COLS-1]) got(3, 0);
      if (res_valid && res_ready) got(4, int'(res_row));
      else if (res_valid) got(5, int'(res_row));
      if (done) got(6, 0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One tile: start driven in cycle s; stall holds res_ready low for that many cycles on row 1.
   task automatic tile(input int k, input int stall, input bit poke);
      int s, d0, done_c, c;
      s  = cyc;
      d0 = s + 2 + k + ROWS + COLS;
      if (k == 0) begin
         done_c = s + 1;
         push(6, done_c, 0);
      end else begin
         done_c = d0 + stall + ROWS;
         push(0, s + 1, 0);
         for (int i = 0; i < k; i++) begin
            push(1, s + 2 + i, rd_word(i));
            push(2, s + 2 + i + ROWS, 0);
            push(3, s + 2 + i + COLS, 0);
         end
         push(4, d0, 0);
         for (int j = 1; j <= stall; j++) push(5, d0 + j, 1);
         for (int r = 1; r < ROWS; r++) push(4, d0 + stall + r, r);
         push(6, done_c, 0);
      end
      start = 1'b1;
      k_len = (ADDR_W+1)'(k);
      while (cyc <= done_c) begin
         step();
         start = 1'b0;
         c = cyc;
         res_ready = !(stall > 0 && c >= d0 + 1 && c <= d0 + stall);
         if (poke && k > 0 && (c == s + 3 || c == d0 + 1)) begin
            start = 1'b1;
            k_len = (ADDR_W+1)'(7);
         end
         chk("busy", int'(busy), int'(c >= s + 1 && c <= done_c));
      end
      res_ready = 1'b1;
   endtask

   task automatic reset_mid_feed();
      int s;
      s = cyc;
      push(0, s + 1, 0);
      for (int i = 0; i < 3; i++) push(1, s + 2 + i, rd_word(i));
      start = 1'b1;
      k_len = (ADDR_W+1)'(4);
      step();
      start = 1'b0;
      step();
      step();
      step();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", int'(all_outs), 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_outs", int'(all_outs), 0);
      step();
      chk("post_reset_busy", int'(busy), 0);
   endtask

   task automatic leftover(input string nm, input int n);
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL %s: %0d expected events never seen", nm, n);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      k_len     = '0;
      res_ready = 1'b1;
      step();
      step();
      chk("reset_outs", int'(all_outs), 0);
      rst_n = 1'b1;
      step();
      chk("idle_outs", int'(all_outs), 0);

      tile(4, 0, 1'b0);
      tile(0, 0, 1'b0);
      tile(K_MAX, 0, 1'b0);
      tile(4, 5, 1'b0);
      tile(3, 0, 1'b1);
      tile(2, 0, 1'b0);
      step();
      reset_mid_feed();
      tile(2, 0, 1'b0);
      step();
      step();

      leftover("acc_clr", q_clr.size());
      leftover("rd", q_rd.size());
      leftover("row_feed3", q_rf.size());
      leftover("col_feed3", q_cf.size());
      leftover("res_hs", q_hs.size());
      leftover("res_stall", q_st.size());
      leftover("done", q_done.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
